// File: rtl/laser_rx_pkg.sv
// Shared types, frame constants and counter-width helpers for the laser receiver array.
package laser_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  function automatic int phase_w(input int oversample);
    return (oversample > 1) ? $clog2(oversample) : 1;
  endfunction

  function automatic int bitcnt_w(input int data_bits);
    return $clog2(data_bits + 2);
  endfunction

  function automatic int win_w(input int align_win);
    return (align_win > 0) ? $clog2(align_win + 1) : 1;
  endfunction

endpackage

// File: rtl/laser_rx_array_if.sv
// Pin-side and delivery-side signal bundle of the laser receiver array.
interface laser_rx_array_if #(
  parameter int NUM_CH    = 2,
  parameter int DATA_BITS = 8
);
  logic [NUM_CH-1:0]           laser_in;
  logic                        group_mode;
  logic [NUM_CH*DATA_BITS-1:0] data_out;
  logic [NUM_CH-1:0]           ch_valid;
  logic [NUM_CH-1:0]           frame_err;
  logic                        group_valid;
  logic                        group_err;

  modport master (
    output laser_in, group_mode,
    input  data_out, ch_valid, frame_err, group_valid, group_err
  );

  modport slave (
    input  laser_in, group_mode,
    output data_out, ch_valid, frame_err, group_valid, group_err
  );
endinterface

// File: rtl/laser_rx_channel.sv
// One laser channel: synchroniser, edge detect, 3-sample majority vote, frame FSM
// and payload shift register.
module laser_rx_channel
  import laser_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 line,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 err,
  output logic                 idle
);

  localparam int PW = phase_w(OVERSAMPLE);
  localparam int BW = bitcnt_w(DATA_BITS);
  localparam logic [PW-1:0] PH_V0    = PW'(OVERSAMPLE/2 - 1);
  localparam logic [PW-1:0] PH_V1    = PW'(OVERSAMPLE/2);
  localparam logic [PW-1:0] PH_DEC   = PW'(OVERSAMPLE/2 + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic sync_p0, sync_p1, edge_p2;
  logic prime_p0, prime_p1, armed;
  logic rise;

  rx_state_t            state, state_n;
  logic [PW-1:0]        phase, phase_n;
  logic [BW-1:0]        bitcnt, bitcnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 v0, v0_n, v1, v1_n;
  logic                 valid_n, err_n;
  logic                 vote, decide;

  // A line already high when reset releases must first be seen low before it can start a frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      edge_p2  <= 1'b0;
      prime_p0 <= 1'b0;
      prime_p1 <= 1'b0;
      armed    <= 1'b0;
    end else begin
      sync_p0  <= line;
      sync_p1  <= sync_p0;
      edge_p2  <= sync_p1;
      prime_p0 <= 1'b1;
      prime_p1 <= prime_p0;
      armed    <= armed | (prime_p1 & ~sync_p1);
    end
  end

  assign rise = armed & sync_p1 & ~edge_p2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      phase  <= '0;
      bitcnt <= '0;
      data   <= '0;
      valid  <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      phase  <= phase_n;
      bitcnt <= bitcnt_n;
      data   <= data_n;
      valid  <= valid_n;
      err    <= err_n;
    end
  end

  always_ff @(posedge clock) begin
    shreg <= shreg_n;
    v0    <= v0_n;
    v1    <= v1_n;
  end

  assign vote   = (v0 & v1) | (v0 & sync_p1) | (v1 & sync_p1);
  assign decide = (phase == PH_DEC);
  assign idle   = (state == IDLE);

  always_comb begin
    state_n  = state;
    phase_n  = (phase == PH_LAST) ? '0 : phase + 1'b1;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    data_n   = data;
    v0_n     = (phase == PH_V0) ? sync_p1 : v0;
    v1_n     = (phase == PH_V1) ? sync_p1 : v1;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        phase_n  = '0;
        bitcnt_n = '0;
        if (rise) state_n = START;
      end
      START: begin
        if (decide) begin
          if (vote == START_BIT) begin
            state_n = DATA;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (decide) begin
          shreg_n = {vote, shreg[DATA_BITS-1:1]};
          if (bitcnt == LAST_BIT) state_n = STOP;
          else                    bitcnt_n = bitcnt + 1'b1;
        end
      end
      STOP: begin
        if (decide) begin
          if (vote == STOP_BIT) begin
            data_n  = shreg;
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/laser_rx_array.sv
// Multi-channel laser receiver: per-channel deframers plus optional aligned group delivery.
module laser_rx_array
  import laser_rx_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int ALIGN_WIN  = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  laser_rx_array_if.slave  bus
);

  localparam int WW = win_w(ALIGN_WIN);
  localparam logic [WW-1:0] WIN_MAX = WW'(ALIGN_WIN);

  logic [NUM_CH-1:0] valid_w, err_w, idle_w;
  logic [NUM_CH-1:0] pending, pend_hit, pend_nx;
  logic [WW-1:0]     win_cnt, win_nx;
  logic              gm_q, gv_q, ge_q, gv_nx, ge_nx;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_BITS-1:0] data_c;

    laser_rx_channel #(
      .DATA_BITS (DATA_BITS),
      .OVERSAMPLE(OVERSAMPLE)
    ) u_ch (
      .clock  (clock),
      .reset_n(reset_n),
      .line   (bus.laser_in[c]),
      .data   (data_c),
      .valid  (valid_w[c]),
      .err    (err_w[c]),
      .idle   (idle_w[c])
    );

    assign bus.data_out[c*DATA_BITS +: DATA_BITS] = data_c;
  end

  assign bus.ch_valid    = valid_w;
  assign bus.frame_err   = err_w;
  assign bus.group_valid = gv_q;
  assign bus.group_err   = ge_q;

  // Mode changes only take effect between frames so a window never straddles a mode switch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gm_q    <= 1'b0;
      pending <= '0;
      win_cnt <= '0;
      gv_q    <= 1'b0;
      ge_q    <= 1'b0;
    end else begin
      gm_q    <= (&idle_w) ? bus.group_mode : gm_q;
      pending <= pend_nx;
      win_cnt <= win_nx;
      gv_q    <= gv_nx;
      ge_q    <= ge_nx;
    end
  end

  assign pend_hit = pending | valid_w;

  // win_cnt equals clocks elapsed since the first completion of the current window.
  always_comb begin
    pend_nx = '0;
    win_nx  = '0;
    gv_nx   = 1'b0;
    ge_nx   = 1'b0;
    if (gm_q) begin
      if ((|pending) && (|err_w)) begin
        ge_nx = 1'b1;
      end else if (&pend_hit) begin
        gv_nx = 1'b1;
      end else if ((|pending) && (win_cnt >= WIN_MAX)) begin
        ge_nx = 1'b1;
      end else begin
        pend_nx = pend_hit;
        if (|pend_hit) win_nx = (win_cnt == WIN_MAX) ? win_cnt : win_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_laser_rx_array.sv
// Scoreboard bench for laser_rx_array: expected pulses queued with stimulus, compared in order.
module tb_laser_rx_array;

  localparam int NUM_CH = 2;
  localparam int DB     = 8;
  localparam int OS     = 8;
  localparam int AW     = 16;
  localparam int MAXW   = 512;
  localparam int K_VAL  = 0;
  localparam int K_ERR  = 1;
  localparam int K_GV   = 2;
  localparam int K_GE   = 3;

  typedef struct packed {
    logic [1:0]  kind;
    logic        ch;
    logic [15:0] data;
    logic [15:0] at;
  } ev_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  laser_rx_array_if #(.NUM_CH(NUM_CH), .DATA_BITS(DB)) bus ();

  laser_rx_array #(
    .NUM_CH(NUM_CH), .DATA_BITS(DB), .OVERSAMPLE(OS), .ALIGN_WIN(AW)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  ev_t        e, o;
  logic [1:0] wave [MAXW];
  int         tests = 0;
  int         fails = 0;

  function automatic ev_t mk(input int kind, input int ch, input logic [15:0] d, input int at);
    ev_t r;
    r.kind = kind[1:0];
    r.ch   = ch[0];
    r.data = d;
    r.at   = at[15:0];
    return r;
  endfunction

  task automatic clear_wave();
    for (int i = 0; i < MAXW; i++) wave[i] = '0;
  endtask

  task automatic put_level(input int ch, input int at, input int len, input logic v);
    for (int i = at; i < at + len; i++) wave[i][ch] = v;
  endtask

  // Frame = start 1, payload LSB first, stop bit; each bit held OS clocks.
  task automatic put_frame(input int ch, input int at, input logic [7:0] d, input logic stop);
    put_level(ch, at, OS, 1'b1);
    for (int b = 0; b < DB; b++) put_level(ch, at + (b + 1) * OS, OS, d[b]);
    put_level(ch, at + (DB + 1) * OS, OS, stop);
  endtask

  // Drive wave[i] just after posedge i; record every output pulse seen after that edge.
  task automatic play(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      bus.laser_in = (i < MAXW) ? wave[i] : 2'b00;
      @(negedge clock);
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.ch_valid[c])  obs_q.push_back(mk(K_VAL, c, bus.data_out, i));
        if (bus.frame_err[c]) obs_q.push_back(mk(K_ERR, c, bus.data_out, i));
      end
      if (bus.group_valid) obs_q.push_back(mk(K_GV, 0, bus.data_out, i));
      if (bus.group_err)   obs_q.push_back(mk(K_GE, 0, bus.data_out, i));
    end
  endtask

  task automatic test_reset();
    bus.laser_in   = '0;
    bus.group_mode = 1'b0;
    reset_n        = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    tests++; if (bus.data_out !== 16'h0000) begin fails++; $display("FAIL reset data_out: got %h want 0000", bus.data_out); end
    tests++; if (bus.ch_valid !== 2'b00) begin fails++; $display("FAIL reset ch_valid: got %b want 00", bus.ch_valid); end
    tests++; if (bus.frame_err !== 2'b00) begin fails++; $display("FAIL reset frame_err: got %b want 00", bus.frame_err); end
    tests++; if (bus.group_valid !== 1'b0) begin fails++; $display("FAIL reset group_valid: got %b want 0", bus.group_valid); end
    tests++; if (bus.group_err !== 1'b0) begin fails++; $display("FAIL reset group_err: got %b want 0", bus.group_err); end
    @(posedge clock);
    #2 reset_n = 1'b1;
    clear_wave();
    play(6);
  endtask

  task automatic test_single();
    clear_wave();
    put_frame(0, 0, 8'hA5, 1'b0);
    exp_q.push_back(mk(K_VAL, 0, 16'h00A5, 81));
    play(110);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
      tests++;
      if (o !== e) begin fails++; $display("FAIL single: got k%0d c%0d d=%h t=%0d want k%0d c%0d d=%h t=%0d", o.kind, o.ch, o.data, o.at, e.kind, e.ch, e.data, e.at); end
    end
    tests++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL single extra: got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_glitch();
    clear_wave();
    put_level(1, 0, 2, 1'b1);
    put_frame(1, 20, 8'h5A, 1'b0);
    exp_q.push_back(mk(K_ERR, 1, 16'h00A5, 9));
    exp_q.push_back(mk(K_VAL, 1, 16'h5AA5, 101));
    play(130);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
      tests++;
      if (o !== e) begin fails++; $display("FAIL glitch: got k%0d c%0d d=%h t=%0d want k%0d c%0d d=%h t=%0d", o.kind, o.ch, o.data, o.at, e.kind, e.ch, e.data, e.at); end
    end
    tests++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL glitch extra: got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_bad_stop();
    clear_wave();
    put_frame(0, 0, 8'h3C, 1'b1);
    exp_q.push_back(mk(K_ERR, 0, 16'h5AA5, 81));
    play(110);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
      tests++;
      if (o !== e) begin fails++; $display("FAIL bad_stop: got k%0d c%0d d=%h t=%0d want k%0d c%0d d=%h t=%0d", o.kind, o.ch, o.data, o.at, e.kind, e.ch, e.data, e.at); end
    end
    tests++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL bad_stop extra: got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_group_aligned();
    bus.group_mode = 1'b1;
    clear_wave();
    put_frame(0, 0, 8'h11, 1'b0);
    put_frame(1, 5, 8'h22, 1'b0);
    exp_q.push_back(mk(K_VAL, 0, 16'h5A11, 81));
    exp_q.push_back(mk(K_VAL, 1, 16'h2211, 86));
    exp_q.push_back(mk(K_GV,  0, 16'h2211, 87));
    play(110);
    clear_wave();
    put_frame(0, 0, 8'h55, 1'b0);
    put_frame(1, 0, 8'h66, 1'b0);
    exp_q.push_back(mk(K_VAL, 0, 16'h6655, 81));
    exp_q.push_back(mk(K_VAL, 1, 16'h6655, 81));
    exp_q.push_back(mk(K_GV,  0, 16'h6655, 82));
    play(110);
    clear_wave();
    put_frame(0, 0, 8'h01, 1'b0);
    put_frame(1, AW, 8'h02, 1'b0);
    exp_q.push_back(mk(K_VAL, 0, 16'h6601, 81));
    exp_q.push_back(mk(K_VAL, 1, 16'h0201, 97));
    exp_q.push_back(mk(K_GV,  0, 16'h0201, 98));
    play(120);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
      tests++;
      if (o !== e) begin fails++; $display("FAIL group_aligned: got k%0d c%0d d=%h t=%0d want k%0d c%0d d=%h t=%0d", o.kind, o.ch, o.data, o.at, e.kind, e.ch, e.data, e.at); end
    end
    tests++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL group_aligned extra: got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_group_errors();
    bus.group_mode = 1'b1;
    clear_wave();
    put_frame(0, 0, 8'h33, 1'b0);
    put_frame(1, 20, 8'h44, 1'b0);
    exp_q.push_back(mk(K_VAL, 0, 16'h0233, 81));
    exp_q.push_back(mk(K_GE,  0, 16'h0233, 98));
    exp_q.push_back(mk(K_VAL, 1, 16'h4433, 101));
    exp_q.push_back(mk(K_GE,  0, 16'h4433, 118));
    play(140);
    clear_wave();
    put_frame(0, 0, 8'h0F, 1'b0);
    put_frame(1, 5, 8'hF0, 1'b1);
    exp_q.push_back(mk(K_VAL, 0, 16'h440F, 81));
    exp_q.push_back(mk(K_ERR, 1, 16'h440F, 86));
    exp_q.push_back(mk(K_GE,  0, 16'h440F, 87));
    play(120);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
      tests++;
      if (o !== e) begin fails++; $display("FAIL group_errors: got k%0d c%0d d=%h t=%0d want k%0d c%0d d=%h t=%0d", o.kind, o.ch, o.data, o.at, e.kind, e.ch, e.data, e.at); end
    end
    tests++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL group_errors extra: got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_mid();
    bus.group_mode = 1'b0;
    clear_wave();
    put_frame(0, 0, 8'hFF, 1'b0);
    put_frame(1, 0, 8'hFF, 1'b0);
    play(40);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    tests++; if (bus.data_out !== 16'h0000) begin fails++; $display("FAIL reset_mid data_out: got %h want 0000", bus.data_out); end
    tests++; if (bus.ch_valid !== 2'b00) begin fails++; $display("FAIL reset_mid ch_valid: got %b want 00", bus.ch_valid); end
    tests++; if (bus.frame_err !== 2'b00) begin fails++; $display("FAIL reset_mid frame_err: got %b want 00", bus.frame_err); end
    tests++; if (bus.group_valid !== 1'b0) begin fails++; $display("FAIL reset_mid group_valid: got %b want 0", bus.group_valid); end
    tests++; if (bus.group_err !== 1'b0) begin fails++; $display("FAIL reset_mid group_err: got %b want 0", bus.group_err); end
    @(posedge clock);
    #2 reset_n = 1'b1;
    clear_wave();
    put_level(1, 0, 30, 1'b1);
    play(150);
    clear_wave();
    put_frame(0, 0, 8'h7E, 1'b0);
    exp_q.push_back(mk(K_VAL, 0, 16'h007E, 81));
    play(110);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
      tests++;
      if (o !== e) begin fails++; $display("FAIL reset_mid: got k%0d c%0d d=%h t=%0d want k%0d c%0d d=%h t=%0d", o.kind, o.ch, o.data, o.at, e.kind, e.ch, e.data, e.at); end
    end
    tests++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL reset_mid extra: got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_bad_stop();
    test_group_aligned();
    test_group_errors();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
